// File: rtl/dm_access_pkg.sv
// dm_access_pkg: shared encodings for the dm_1k load/store sequencer.
// Holds access-size codes, the sequencer state enum and the memory size.
package dm_access_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DM_BYTES   = 2 ** DEF_ADDR_W;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAP,
        WR,
        RESP
    } state_t;

endpackage

// File: rtl/load_extend.sv
// load_extend: picks the low byte/half/word of a captured memory word and
// sign- or zero-extends it to 32 bits. Word loads pass through unchanged.
module load_extend
    import dm_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    // Select width and fill bits from the access size
    always_comb begin
        data = word;
        case (size)
            SZ_BYTE: data = {{24{sign_ext & word[7]}}, word[7:0]};
            SZ_HALF: data = {{16{sign_ext & word[15]}}, word[15:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: load/store sequencer in front of dm_1k (byte addressed,
// little endian, word-only writes). Sub-word stores are read-modify-write.
// Optional macro DM_ALIGN_CHECK_EN: reject misaligned half/word accesses.
module dm_access_unit
    import dm_access_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout,
    output logic              dm_we
);

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic              signed_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cap_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [1:0]        end_off;
    logic [ADDR_W:0]   end_addr;
    logic              misalign;
    logic              acc_err;
    logic              accept;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    assign accept = (state == IDLE) && req_valid;

    // Last byte touched by the request, with a carry bit to catch overrun
    always_comb begin
        end_off = 2'd0;
        case (req_size)
            SZ_HALF: end_off = 2'd1;
            SZ_WORD: end_off = 2'd3;
            default: end_off = 2'd0;
        endcase
        end_addr = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, end_off};
    end

`ifdef DM_ALIGN_CHECK_EN
    // Misaligned half/word accesses are address errors
    always_comb begin
        misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    end
`else
    // dm_1k is byte-granular, so any alignment is accepted
    always_comb begin
        misalign = 1'b0;
    end
`endif

    assign acc_err = end_addr[ADDR_W] || (req_size == SZ_RSVD) || misalign;

    load_extend u_load_extend (
        .word     (dm_dout),
        .size     (size_q),
        .sign_ext (signed_q),
        .data     (load_data)
    );

    // Splice new store data over the captured word for sub-word stores
    always_comb begin
        merged = wdata_q;
        case (size_q)
            SZ_BYTE: merged = {cap_q[31:8], wdata_q[7:0]};
            SZ_HALF: merged = {cap_q[31:16], wdata_q[15:0]};
            default: merged = wdata_q;
        endcase
    end

    // State register; reset drops any in-flight access immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing and memory-side outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        dm_din     = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (acc_err) begin
                        state_next = RESP;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                dm_addr    = addr_q;
                state_next = RD_CAP;
            end
            RD_CAP: begin
                dm_addr    = addr_q;
                state_next = write_q ? WR : RESP;
            end
            WR: begin
                dm_addr    = addr_q;
                dm_din     = merged;
                dm_we      = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch at accept, memory word capture at the end of RD_CAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            size_q   <= SZ_BYTE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            cap_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            write_q  <= req_write;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= acc_err;
        end else if (state == RD_CAP) begin
            cap_q <= dm_dout;
            if (!write_q) begin
                rdata_q <= load_data;
            end
        end
    end

    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = (state == RESP) ? rdata_q : '0;

endmodule
